// File: rtl/reg_bank.sv
// reg_bank: 16 x 64-bit operand store with one write port (full, high-half,
// low-half or in-place swap) and two independently registered read ports.
module reg_bank #(
    parameter logic [63:0] CNST_A = 64'd0,
    parameter logic [63:0] CNST_B = 64'd0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        regwen,
    input  logic [63:0] inA,
    input  logic [3:0]  selwreg,
    input  logic [1:0]  endreg,
    input  logic [3:0]  seloutA,
    input  logic [3:0]  seloutB,
    input  logic        cnstA,
    input  logic        cnstB,
    input  logic        enrregA,
    input  logic        enrregB,
    output logic [63:0] outA,
    output logic [63:0] outB
);

    logic [15:0][63:0] bank;
    logic [63:0]       cur_word;
    logic [63:0]       wr_word;

    assign cur_word = bank[selwreg];

    // Merge write data into the addressed entry; a cleared endreg bit opens
    // its half to inA, both bits set swaps the halves and ignores inA.
    always_comb begin
        wr_word = cur_word;
        case (endreg)
            2'b00:   wr_word = inA;
            2'b10:   wr_word[31:0]  = inA[31:0];
            2'b01:   wr_word[63:32] = inA[63:32];
            default: wr_word = {cur_word[31:0], cur_word[63:32]};
        endcase
    end

    // Bank storage: reset clears every entry and discards a concurrent write.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            bank <= '0;
        end else if (regwen) begin
            bank[selwreg] <= wr_word;
        end
    end

    // Read registers sample the bank before this edge's write (no bypass).
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            outA <= '0;
            outB <= '0;
        end else begin
            if (enrregA) outA <= cnstA ? CNST_A : bank[seloutA];
            if (enrregB) outB <= cnstB ? CNST_B : bank[seloutB];
        end
    end

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed plan plus randomized traffic against an array model;
// a second instance carries non-zero constants to cover parameter overrides.
module tb_reg_bank;

    localparam logic [63:0] C2A = 64'hDEADBEEF;
    localparam logic [63:0] C2B = 64'h01234567_89ABCDEF;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        regwen;
    logic [63:0] inA;
    logic [3:0]  selwreg;
    logic [1:0]  endreg;
    logic [3:0]  seloutA;
    logic [3:0]  seloutB;
    logic        cnstA;
    logic        cnstB;
    logic        enrregA;
    logic        enrregB;
    logic [63:0] outA, outB, outA2, outB2;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] mbank [16];
    logic [63:0] exp_a, exp_b, exp_a2, exp_b2;

    reg_bank dut (
        .clock(clock), .reset_n(reset_n), .regwen(regwen), .inA(inA),
        .selwreg(selwreg), .endreg(endreg), .seloutA(seloutA), .seloutB(seloutB),
        .cnstA(cnstA), .cnstB(cnstB), .enrregA(enrregA), .enrregB(enrregB),
        .outA(outA), .outB(outB)
    );

    reg_bank #(.CNST_A(C2A), .CNST_B(C2B)) dut2 (
        .clock(clock), .reset_n(reset_n), .regwen(regwen), .inA(inA),
        .selwreg(selwreg), .endreg(endreg), .seloutA(seloutA), .seloutB(seloutB),
        .cnstA(cnstA), .cnstB(cnstB), .enrregA(enrregA), .enrregB(enrregB),
        .outA(outA2), .outB(outB2)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference write rule: each half comes either from inA or from the old
    // entry, except mode 3 which exchanges the halves.
    function automatic logic [63:0] wmodel(input logic [63:0] old, input logic [63:0] d,
                                           input logic [1:0] mode);
        logic [31:0] hi, lo;
        if (mode == 2'b11) return {old[31:0], old[63:32]};
        hi = mode[1] ? old[63:32] : d[63:32];
        lo = mode[0] ? old[31:0]  : d[31:0];
        return {hi, lo};
    endfunction

    // One clock: predict from pre-edge state, advance, then compare.
    task automatic tick();
        logic [63:0] na, nb, na2, nb2;
        na = exp_a; nb = exp_b; na2 = exp_a2; nb2 = exp_b2;
        if (!reset_n) begin
            na = 0; nb = 0; na2 = 0; nb2 = 0;
        end else begin
            if (enrregA) begin
                na  = cnstA ? 64'd0 : mbank[seloutA];
                na2 = cnstA ? C2A   : mbank[seloutA];
            end
            if (enrregB) begin
                nb  = cnstB ? 64'd0 : mbank[seloutB];
                nb2 = cnstB ? C2B   : mbank[seloutB];
            end
        end
        @(posedge clock);
        #1;
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) mbank[i] = 64'd0;
        end else if (regwen) begin
            mbank[selwreg] = wmodel(mbank[selwreg], inA, endreg);
        end
        exp_a = na; exp_b = nb; exp_a2 = na2; exp_b2 = nb2;
        chk("outA",  outA,  exp_a);
        chk("outB",  outB,  exp_b);
        chk("outA2", outA2, exp_a2);
        chk("outB2", outB2, exp_b2);
    endtask

    task automatic wr(input logic [3:0] sel, input logic [63:0] d, input logic [1:0] mode);
        regwen = 1'b1; selwreg = sel; inA = d; endreg = mode;
        enrregA = 1'b0; enrregB = 1'b0;
        tick();
        regwen = 1'b0;
    endtask

    task automatic rd(input logic [3:0] sa, input logic [3:0] sb, input logic ca, input logic cb);
        seloutA = sa; seloutB = sb; cnstA = ca; cnstB = cb;
        enrregA = 1'b1; enrregB = 1'b1;
        tick();
        enrregA = 1'b0; enrregB = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; regwen = 1'b0; inA = '0; selwreg = '0; endreg = '0;
        seloutA = '0; seloutB = '0; cnstA = 1'b0; cnstB = 1'b0;
        enrregA = 1'b0; enrregB = 1'b0;
        exp_a = 0; exp_b = 0; exp_a2 = 0; exp_b2 = 0;
        for (int i = 0; i < 16; i++) mbank[i] = 64'd0;

        // 1. reset
        for (int i = 0; i < 20; i++) tick();
        reset_n = 1'b1;
        rd(4'd0, 4'd15, 1'b0, 1'b0);
        chk("rst_a", outA, 64'd0);
        chk("rst_b", outB, 64'd0);
        rd(4'd15, 4'd0, 1'b0, 1'b0);
        chk("rst_a15", outA, 64'd0);

        // 2. full write and hold
        wr(4'hA, 64'd24, 2'b00);
        wr(4'hB, 64'd25, 2'b00);
        rd(4'hA, 4'hB, 1'b0, 1'b0);
        chk("full_a", outA, 64'd24);
        chk("full_b", outB, 64'd25);
        seloutA = 4'h1; seloutB = 4'h2;
        tick(); tick();
        chk("hold_a", outA, 64'd24);
        chk("hold_b", outB, 64'd25);

        // 3. partial writes and swap
        wr(4'd3, 64'h11112222_33334444, 2'b00);
        wr(4'd3, 64'hAAAAAAAA_BBBBBBBB, 2'b10);
        rd(4'd3, 4'd3, 1'b0, 1'b0);
        chk("lo_half", outA, 64'h11112222_BBBBBBBB);
        wr(4'd3, 64'hAAAAAAAA_BBBBBBBB, 2'b01);
        rd(4'd3, 4'd3, 1'b0, 1'b0);
        chk("hi_half", outB, 64'hAAAAAAAA_BBBBBBBB);
        wr(4'd3, 64'd0, 2'b11);
        rd(4'd3, 4'd3, 1'b0, 1'b0);
        chk("swap", outA, 64'hBBBBBBBB_AAAAAAAA);

        // 4. constants with non-zero entries
        rd(4'hA, 4'hB, 1'b1, 1'b1);
        chk("cnst_a", outA, 64'd0);
        chk("cnst_b", outB, 64'd0);
        chk("cnst_a2", outA2, 64'hDEADBEEF);
        chk("cnst_b2", outB2, C2B);
        rd(4'd3, 4'hB, 1'b0, 1'b1);
        chk("mix_a2", outA2, 64'hBBBBBBBB_AAAAAAAA);
        chk("mix_b2", outB2, C2B);

        // 5. read during write: old data first, new data next cycle
        wr(4'd5, 64'd7, 2'b00);
        regwen = 1'b1; selwreg = 4'd5; inA = 64'd9; endreg = 2'b00;
        seloutA = 4'd5; cnstA = 1'b0; enrregA = 1'b1;
        tick();
        chk("rdw_old", outA, 64'd7);
        regwen = 1'b0;
        tick();
        chk("rdw_new", outA, 64'd9);
        enrregA = 1'b0;

        // 6. reset discards a concurrent write; regwen=0 changes nothing
        wr(4'd2, 64'h99, 2'b00);
        reset_n = 1'b0; regwen = 1'b1; selwreg = 4'd2; inA = 64'h55; endreg = 2'b00;
        tick();
        reset_n = 1'b1; regwen = 1'b0;
        rd(4'd2, 4'd2, 1'b0, 1'b0);
        chk("rst_wr_a", outA, 64'd0);
        chk("rst_wr_b", outB, 64'd0);
        wr(4'd7, 64'h12345678_9ABCDEF0, 2'b00);
        for (int i = 0; i < 8; i++) begin
            regwen = 1'b0; endreg = 2'b11;
            selwreg = 4'($urandom_range(0, 15));
            inA = {$urandom(), $urandom()};
            tick();
        end
        rd(4'd7, 4'd7, 1'b0, 1'b0);
        chk("nowen", outA, 64'h12345678_9ABCDEF0);
        for (int i = 0; i < 16; i++) rd(4'(i), 4'(15 - i), 1'b0, 1'b0);

        // randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            reset_n = ($urandom_range(0, 40) != 0);
            regwen  = 1'($urandom_range(0, 1));
            inA     = {$urandom(), $urandom()};
            selwreg = 4'($urandom_range(0, 15));
            endreg  = 2'($urandom_range(0, 3));
            seloutA = 4'($urandom_range(0, 15));
            seloutB = 4'($urandom_range(0, 15));
            cnstA   = ($urandom_range(0, 5) == 0);
            cnstB   = ($urandom_range(0, 5) == 0);
            enrregA = 1'($urandom_range(0, 1));
            enrregB = 1'($urandom_range(0, 1));
            tick();
        end

        reset_n = 1'b1; regwen = 1'b0;
        for (int i = 0; i < 16; i++) rd(4'(i), 4'(i), 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- 16-entry by 64-bit register bank with one write port and two independently registered read ports, A and B.
- Writes can update the full word, only the high or low 32-bit half, or swap the halves of the addressed entry in place.
- Each output port loads either the selected bank entry or a fixed constant, and only when its read enable is asserted.
- Sits in the datapath as the general-purpose operand store feeding downstream arithmetic.

Parameters:
- CNST_A, 64'd0, constant loaded into outA when cnstA=1
- CNST_B, 64'd0, constant loaded into outB when cnstB=1

Ports:
- clock  in  1  master clock, all state updates on posedge
- reset_n  in  1  synchronous reset, active low
- regwen  in  1  write enable for entry selwreg
- inA  in  64  write data
- selwreg  in  4  write entry index, 0-15
- endreg  in  2  write mode; bit0=0 enables the low half [31:0], bit1=0 enables the high half [63:32]; 11 = swap
- seloutA  in  4  read index for port A
- seloutB  in  4  read index for port B
- cnstA  in  1  1: outA source is CNST_A; 0: outA source is bank[seloutA]
- cnstB  in  1  1: outB source is CNST_B; 0: outB source is bank[seloutB]
- enrregA  in  1  load enable for the outA register
- enrregB  in  1  load enable for the outB register
- outA  out  64  registered read data, port A
- outB  out  64  registered read data, port B

Behaviour:
- Reset: on a posedge with reset_n=0, all 16 entries, outA and outB become 64'd0. Reset has priority over write and read enables. A write pending in the reset cycle is discarded.
- Write: on a posedge with regwen=1, entry E=selwreg is updated according to endreg:
  - 00: E <= inA
  - 10: E[31:0] <= inA[31:0]; high half held
  - 01: E[63:32] <= inA[63:32]; low half held
  - 11: E <= {E[31:0], E[63:32]} (swap); inA ignored
- regwen=0: no entry changes, whatever selwreg, endreg and inA are.
- Write latency: one clock; the new value is visible to reads from the next cycle onward.
- Read: on a posedge with enrregA=1, outA <= cnstA ? CNST_A : bank[seloutA]. Port B is identical, using enrregB, cnstB, seloutB and CNST_B.
- Read enable deasserted: the output register holds its value.
- Read latency: data appears one posedge after the enable is sampled.
- Read and write same entry in the same cycle: the output gets the pre-write (old) contents. There is no bypass.
- A and B may select the same entry, or both use constants, simultaneously with no interaction.
- All inputs are sampled only at posedge; there is no combinational path from any input to outA or outB.

Test Plan:
1. Reset: hold reset_n=0 for 20 cycles, release, read entries 0 and 15 on A and B -> outA=outB=0.
2. Full write: write 24 to entry 0xA and 25 to entry 0xB (endreg=00), then read A=0xA and B=0xB with enables -> outA=24, outB=25 one cycle later. Deassert the enables and change the selects -> outputs hold 24 and 25.
3. Partial writes and swap:
   - Entry 3 = 64'h11112222_33334444.
   - Write inA=64'hAAAAAAAA_BBBBBBBB with endreg=10 -> entry 3 = 64'h11112222_BBBBBBBB.
   - Then endreg=01 -> entry 3 = 64'hAAAAAAAA_BBBBBBBB.
   - Then endreg=11 with inA=0 -> entry 3 = 64'hBBBBBBBB_AAAAAAAA.
4. Constants: cnstA=1, cnstB=1, enrregA=enrregB=1 with entries nonzero -> outA=CNST_A, outB=CNST_B (0 at default). With a CNST_A=64'hDEADBEEF override -> outA=64'hDEADBEEF.
5. Read during write: entry 5 = 7. In one cycle, write 9 to entry 5 and read A from 5 -> outA=7. Read again the next cycle -> outA=9.
6. Reset mid-operation: assert reset_n=0 in the same cycle as regwen=1 writing 0x55 to entry 2 -> entry 2=0, outA=0 after release. regwen=0 with endreg=11 -> no entry changes.
